// File: rtl/bkd2obuf.sv
// bkd2obuf: packs a backend AXI-Stream packet stream into a circular obuf as one header qword
// plus data qwords, publishing committed_prod only after a packet's header is written.
// Optional macro BKD2OBUF_DROP_EN: drop packets that overflow the obuf instead of stalling.
module bkd2obuf #(
  parameter int BW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   s_axis_tdata,
  input  logic [7:0]    s_axis_tstrb,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [BW:0]   committed_prod,
  input  logic [BW:0]   committed_cons,
`ifdef BKD2OBUF_DROP_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic [2:0]    dbg_state
);

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and s_axis_tready are
  // both high; s_axis_tready never depends on s_axis_tvalid, and tvalid must hold until taken.

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_DATA = 3'd2,
`ifdef BKD2OBUF_DROP_EN
    S_HDR  = 3'd3,
    S_DROP = 3'd4
`else
    S_HDR  = 3'd3
`endif
  } state_t;

`ifdef BKD2OBUF_DROP_EN
  localparam int HPW = BW + 1;
`else
  localparam int HPW = BW;
`endif
  localparam logic [BW+1:0] DEPTH = {2'b01, {BW{1'b0}}};

  state_t        state, state_d;
  logic [BW:0]   wr_ptr;
  logic [HPW-1:0] hdr_ptr;
  logic [BW:0]   cons_q;
  logic [12:0]   qw_cnt;
  logic [3:0]    last_bytes;
  logic          pub_q;
  logic [BW:0]   used;
  logic [BW+1:0] free;
  logic          has_two, full, beat;
  logic [15:0]   hdr_len;

  // committed_cons is registered so a consumer update lands in the free count one cycle later
  assign used    = wr_ptr - cons_q;
  assign free    = DEPTH - {1'b0, used};
  assign has_two = free >= (BW+2)'(2);
  assign full    = free == '0;
  assign beat    = s_axis_tvalid && s_axis_tready;
  assign hdr_len = {qw_cnt - 13'd1, 3'b000} + {12'd0, last_bytes};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_d;
  end

  always_comb begin
    state_d       = state;
    s_axis_tready = 1'b0;
    case (state)
      S_INIT: state_d = S_IDLE;
      S_IDLE: if (has_two) state_d = S_DATA;
      S_DATA: begin
`ifdef BKD2OBUF_DROP_EN
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && full)             state_d = s_axis_tlast ? S_IDLE : S_DROP;
        else if (s_axis_tvalid && s_axis_tlast) state_d = S_HDR;
`else
        s_axis_tready = !full;
        if (s_axis_tvalid && !full && s_axis_tlast) state_d = S_HDR;
`endif
      end
      S_HDR: state_d = S_IDLE;
`ifdef BKD2OBUF_DROP_EN
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = S_IDLE;
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      hdr_ptr        <= '0;
      cons_q         <= '0;
      qw_cnt         <= '0;
      last_bytes     <= '0;
      pub_q          <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      committed_prod <= '0;
`ifdef BKD2OBUF_DROP_EN
      drop_cnt       <= '0;
`endif
    end else begin
      cons_q <= committed_cons;
      wr_en  <= 1'b0;
      pub_q  <= 1'b0;
      // publish one cycle after the header write so the consumer only sees whole packets
      if (pub_q) committed_prod <= wr_ptr;
      case (state)
        S_INIT: begin
          wr_ptr         <= '0;
          committed_prod <= '0;
        end
        S_IDLE: if (has_two) begin
          hdr_ptr <= wr_ptr[HPW-1:0];
          wr_ptr  <= wr_ptr + 1'b1;
          qw_cnt  <= '0;
        end
        S_DATA: if (beat) begin
`ifdef BKD2OBUF_DROP_EN
          if (full) begin
            wr_ptr <= hdr_ptr;
            if (drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
          end else begin
`endif
            wr_en   <= 1'b1;
            wr_addr <= wr_ptr[BW-1:0];
            wr_data <= s_axis_tdata;
            wr_ptr  <= wr_ptr + 1'b1;
            qw_cnt  <= qw_cnt + 13'd1;
            if (s_axis_tlast) last_bytes <= 4'($countones(s_axis_tstrb));
`ifdef BKD2OBUF_DROP_EN
          end
`endif
        end
        S_HDR: begin
          wr_en   <= 1'b1;
          wr_addr <= hdr_ptr[BW-1:0];
          wr_data <= {16'h0000, hdr_len, 32'h0000_0000};
          pub_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
